// File: rtl/sdram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_port_arbiter_pkg
//  Description : Shared types and helpers for the two-port SDRAM arbiter.
//                Holds the arbiter FSM state encoding, the captured request
//                record and the round-robin pick function.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdram_port_arbiter_pkg;

    localparam int unsigned c_ADDR_W = 32;
    localparam int unsigned c_DATA_W = 32;
    localparam int unsigned c_BE_W   = 4;

    // Arbiter FSM states; exactly one transaction is in flight at a time.
    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_ISSUE    = 2'd1,
        ARB_WAIT_ACK = 2'd2
    } arb_state_t;

    // One requester's command as seen on its port / as presented downstream.
    typedef struct packed {
        logic                rd;
        logic [c_BE_W-1:0]   wr;
        logic [c_ADDR_W-1:0] addr;
        logic [c_DATA_W-1:0] data;
    } arb_cmd_t;

    // Round-robin pick between two requesters. On a tie the requester that
    // was NOT served last wins; with a single requester that one wins.
    function automatic logic rr_pick(input logic req0,
                                     input logic req1,
                                     input logic last_grant);
        logic pick;
        if (req0 && req1) begin
            pick = ~last_grant;
        end else begin
            pick = req1;
        end
        return pick;
    endfunction

endpackage : sdram_port_arbiter_pkg
`default_nettype wire

// File: rtl/sdram_ack_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_ack_watchdog
//  Description : Acknowledge watchdog. Counts cycles spent waiting for an
//                acknowledge, saturates at ACK_TIMEOUT and raises a sticky
//                flag when the limit is reached without an acknowledge.
//                The flag is cleared only by reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_ack_watchdog
    import sdram_port_arbiter_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,      // asynchronous, active-low
    input  logic clear_i,    // restart the count (entering the wait)
    input  logic enable_i,   // one waiting cycle without acknowledge
    output logic timeout_o
);

    localparam int unsigned c_CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_CNT_W:0] c_LIMIT = (c_CNT_W + 1)'(ACK_TIMEOUT);

    logic [c_CNT_W-1:0] r_count;
    logic               r_timeout;
    logic [c_CNT_W:0]   w_count_next;
    logic               w_at_limit;

    // Count value after this cycle if it advances; one extra bit so the
    // comparison against the limit never wraps.
    assign w_count_next = {1'b0, r_count} + {{c_CNT_W{1'b0}}, 1'b1};
    assign w_at_limit   = ({1'b0, r_count} >= c_LIMIT);

    // Wait-cycle counter: restart on clear, advance while waiting, hold at limit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_count <= '0;
        end else if (clear_i) begin
            r_count <= '0;
        end else if (enable_i && !w_at_limit) begin
            r_count <= w_count_next[c_CNT_W-1:0];
        end
    end

    // Sticky flag: set on the waiting cycle that brings the count to the limit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_timeout <= 1'b0;
        end else if (!clear_i && enable_i && (w_count_next >= c_LIMIT)) begin
            r_timeout <= 1'b1;
        end
    end

    assign timeout_o = r_timeout;

endmodule : sdram_ack_watchdog
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_port_arbiter
//  Description : Two-requester round-robin arbiter in front of a single
//                SDRAM controller inport. A granted request is captured into
//                registers and presented downstream until accepted; the
//                acknowledge is routed back to the granted requester. An
//                acknowledge watchdog raises a sticky timeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter
    import sdram_port_arbiter_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,              // asynchronous, active-low

    // Requester 0
    input  logic [c_BE_W-1:0]   m0_wr_i,
    input  logic                m0_rd_i,
    input  logic [c_ADDR_W-1:0] m0_addr_i,
    input  logic [c_DATA_W-1:0] m0_write_data_i,
    output logic                m0_accept_o,
    output logic                m0_ack_o,
    output logic [c_DATA_W-1:0] m0_read_data_o,

    // Requester 1
    input  logic [c_BE_W-1:0]   m1_wr_i,
    input  logic                m1_rd_i,
    input  logic [c_ADDR_W-1:0] m1_addr_i,
    input  logic [c_DATA_W-1:0] m1_write_data_i,
    output logic                m1_accept_o,
    output logic                m1_ack_o,
    output logic [c_DATA_W-1:0] m1_read_data_o,

    // SDRAM controller inport
    output logic [c_BE_W-1:0]   outport_wr_o,
    output logic                outport_rd_o,
    output logic [c_ADDR_W-1:0] outport_addr_o,
    output logic [c_DATA_W-1:0] outport_write_data_o,
    input  logic                outport_accept_i,
    input  logic                outport_ack_i,
    input  logic [c_DATA_W-1:0] outport_read_data_i,

    // Status
    output logic                grant_o,
    output logic                timeout_o
);

    arb_state_t r_state;
    logic       r_grant;        // requester owning the current / last transaction
    logic       r_last_grant;   // requester whose transaction completed last
    arb_cmd_t   r_cmd;          // captured command driving the outport

    logic       w_req0;
    logic       w_req1;
    logic       w_pick;
    arb_cmd_t   w_cmd0;
    arb_cmd_t   w_cmd1;
    arb_cmd_t   w_sel_cmd;
    logic       w_issue_accept;
    logic       w_ack_valid;
    logic       w_wd_clear;
    logic       w_wd_enable;

    // Request decode and command selection for the arbitration cycle.
    assign w_req0    = m0_rd_i | (|m0_wr_i);
    assign w_req1    = m1_rd_i | (|m1_wr_i);
    assign w_cmd0    = {m0_rd_i, m0_wr_i, m0_addr_i, m0_write_data_i};
    assign w_cmd1    = {m1_rd_i, m1_wr_i, m1_addr_i, m1_write_data_i};
    assign w_pick    = rr_pick(w_req0, w_req1, r_last_grant);
    assign w_sel_cmd = w_pick ? w_cmd1 : w_cmd0;

    // Handshake qualification. An acknowledge only counts while a transaction
    // is actually outstanding, so a stray acknowledge in IDLE is dropped.
    assign w_issue_accept = (r_state == ARB_ISSUE) && outport_accept_i;
    assign w_ack_valid    = outport_ack_i &&
                            (w_issue_accept || (r_state == ARB_WAIT_ACK));

    // Watchdog restarts when the wait begins and counts un-acknowledged waits.
    assign w_wd_clear  = w_issue_accept && !outport_ack_i;
    assign w_wd_enable = (r_state == ARB_WAIT_ACK) && !outport_ack_i;

    // Arbiter FSM: arbitrate in IDLE, present the captured command in ISSUE,
    // wait for the controller's acknowledge in WAIT_ACK.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= ARB_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_cmd        <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_req0 || w_req1) begin
                        r_grant <= w_pick;
                        r_cmd   <= w_sel_cmd;
                        r_state <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (outport_accept_i) begin
                        // Request leaves the outport as soon as it is taken.
                        r_cmd.rd <= 1'b0;
                        r_cmd.wr <= '0;
                        if (outport_ack_i) begin
                            r_last_grant <= r_grant;
                            r_state      <= ARB_IDLE;
                        end else begin
                            r_state      <= ARB_WAIT_ACK;
                        end
                    end
                end
                ARB_WAIT_ACK: begin
                    // Stays here past a timeout; a late acknowledge still completes.
                    if (outport_ack_i) begin
                        r_last_grant <= r_grant;
                        r_state      <= ARB_IDLE;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_cmd   <= '0;
                end
            endcase
        end
    end

    sdram_ack_watchdog #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_ack_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (w_wd_clear),
        .enable_i  (w_wd_enable),
        .timeout_o (timeout_o)
    );

    // Downstream request comes only from the captured registers.
    assign outport_rd_o         = r_cmd.rd;
    assign outport_wr_o         = r_cmd.wr;
    assign outport_addr_o       = r_cmd.addr;
    assign outport_write_data_o = r_cmd.data;

    // Per-requester handshakes; the non-granted side always sees zero.
    assign m0_accept_o = w_issue_accept && !r_grant;
    assign m1_accept_o = w_issue_accept &&  r_grant;
    assign m0_ack_o    = w_ack_valid    && !r_grant;
    assign m1_ack_o    = w_ack_valid    &&  r_grant;

    // Read data is a plain passthrough, qualified by the ack pulse.
    assign m0_read_data_o = outport_read_data_i;
    assign m1_read_data_o = outport_read_data_i;

    assign grant_o = r_grant;

endmodule : sdram_port_arbiter
`default_nettype wire

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameter ACK_TIMEOUT, default 255: cycles allowed in WAIT_ACK before timeout_o asserts.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 m0_wr_i / m1_wr_i  input  4  byte write enables of requester 0/1.
REQ-005 m0_rd_i / m1_rd_i  input  1  read request of requester 0/1.
REQ-006 m0_addr_i / m1_addr_i  input  32  byte address.
REQ-007 m0_write_data_i / m1_write_data_i  input  32  write data.
REQ-008 m0_accept_o / m1_accept_o  output  1  request taken by controller.
REQ-009 m0_ack_o / m1_ack_o  output  1  transaction complete, one-cycle pulse.
REQ-010 m0_read_data_o / m1_read_data_o  output  32  read data, valid with ack.
REQ-011 outport_wr_o  output  4, outport_rd_o  output  1: request to SDRAM controller inport.
REQ-012 outport_addr_o  output  32, outport_write_data_o  output  32: captured address/data.
REQ-013 outport_accept_i  input  1, outport_ack_i  input  1, outport_read_data_i  input  32: controller responses.
REQ-014 grant_o  output  1  index of current/last granted requester.
REQ-015 timeout_o  output  1  sticky ack-timeout error flag.

Function
REQ-016 Request from requester N SHALL be mN_rd_i | (|mN_wr_i); requesters SHALL hold request stable until mN_accept_o.
REQ-017 FSM states: IDLE, ISSUE, WAIT_ACK; exactly one transaction outstanding at a time.
REQ-018 IDLE, one request: grant that requester; both requesting: grant requester != last_grant (round-robin); none: stay IDLE.
REQ-019 IDLE->ISSUE SHALL capture granted wr/rd/addr/write_data into registers; outport_* driven only from these registers.
REQ-020 Minimum latency: request seen in IDLE at cycle 0 -> outport_rd_o/outport_wr_o asserted cycle 1.
REQ-021 Outside ISSUE, outport_rd_o=0 and outport_wr_o=4'b0000.
REQ-022 mN_accept_o = (state==ISSUE) && (grant==N) && outport_accept_i, combinational, same cycle.
REQ-023 ISSUE with outport_accept_i -> WAIT_ACK; without -> stay ISSUE, request held.
REQ-024 ISSUE with outport_accept_i and outport_ack_i both high -> IDLE directly, ack forwarded that cycle.
REQ-025 mN_ack_o = outport_ack_i && grant==N && state in {ISSUE-with-accept, WAIT_ACK}; outport_ack_i in IDLE SHALL be ignored.
REQ-026 mN_read_data_o SHALL equal outport_read_data_i continuously; qualified by mN_ack_o only.
REQ-027 On ack: last_grant <= grant; next state IDLE; new requests arbitrated from IDLE next cycle (no same-cycle re-grant).
REQ-028 Watchdog counter clears on entering WAIT_ACK, increments each WAIT_ACK cycle, saturates at ACK_TIMEOUT.
REQ-029 Counter reaching ACK_TIMEOUT without ack SHALL set timeout_o, held until reset; FSM stays WAIT_ACK, a late ack still completes normally.
REQ-030 Non-granted requester SHALL see accept=0 and ack=0 regardless of its request.

Reset
REQ-031 rst_i low SHALL immediately force: state IDLE, last_grant 1 (requester 0 wins first tie), grant_o 0, captured registers 0, counter 0, timeout_o 0.
REQ-032 Reset mid-transaction SHALL abandon it; no ack forwarded after release for the pre-reset request.
REQ-033 All outputs SHALL be 0 during reset except read_data passthrough.

Structure
REQ-034 FSM state typedef (ARB_IDLE/ARB_ISSUE/ARB_WAIT_ACK) SHALL live in shared package definitions.
REQ-035 Watchdog SHALL be sub-module sdram_ack_watchdog (clear, enable, ACK_TIMEOUT parameter, sticky flag out).

Verification
REQ-036 m0_rd_i=1, addr 0x0000_1000 cycle 0; accept cycle 2; ack cycle 6 -> outport_rd_o cycles 1-2, m0_accept_o cycle 2, m0_ack_o cycle 6 with data 0xDEAD_BEEF.
REQ-037 m0 and m1 both request continuously from reset -> grant order 0,1,0,1; never two consecutive grants to same requester.
REQ-038 m1_wr_i=4'b0011, data 0x1234_5678; outport_accept_i held low 5 cycles -> outport signals stable all 5 cycles, m1_accept_o only when accept rises.
REQ-039 ACK_TIMEOUT=8, accept then no ack -> timeout_o high after 8 WAIT_ACK cycles, stays high; ack at cycle 12 -> m0_ack_o pulses, FSM IDLE.
REQ-040 rst_i low in WAIT_ACK, released, then outport_ack_i pulse -> no mN_ack_o; state IDLE, timeout_o 0.
REQ-041 outport_ack_i and outport_accept_i high same ISSUE cycle -> accept and ack pulse together, IDLE next cycle.
